// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding and image format constants.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Length prefix is two bytes, big-endian; words arrive MSB first.
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Shifts incoming bytes MSB-first into a 32-bit word and raises a
// one-cycle word_valid in the cycle after the final byte is taken.
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      word_reg;
  logic             valid_reg;

  // The byte currently offered completes a word when the counter is at its top.
  assign last_byte  = (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));
  assign word_valid = valid_reg;
  assign word       = word_reg;

  // Byte counter, shift register and the registered word-complete pulse.
  // A byte shifted in during the pulse cycle only changes word_reg at the
  // end of that cycle, so the completed word is still presented intact.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= shift_en && last_byte;
      if (shift_en) begin
        word_reg <= {word_reg[23:0], byte_in};
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a length-prefixed, XOR-checksummed image,
// writes big-endian words to instruction memory from address 0 and holds
// the CPU in reset until an image has been accepted.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int LEN_W = LEN_BYTES * 8;
  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

  state_t                state_reg, state_next;
  logic [7:0]            acc_reg;
  logic [7:0]            len_hi_reg;
  logic [ADDR_WIDTH:0]   len_reg;
  logic [ADDR_WIDTH:0]   word_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   loaded_reg;

  logic              launch;
  logic              data_take;
  logic              word_end;
  logic              last_byte;
  logic              word_valid;
  logic [31:0]       word;
  logic [LEN_W-1:0]  n_full;

  assign launch    = start && (state_reg inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign data_take = rx_valid && (state_reg == ST_DATA);
  assign word_end  = data_take && last_byte;
  assign n_full    = {len_hi_reg, rx_data};

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .shift_en   (data_take),
    .byte_in    (rx_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  assign imem_we      = word_valid;
  assign imem_wdata   = word;
  assign imem_addr    = addr_reg;
  assign words_loaded = loaded_reg;

  // Next-state and state-decoded outputs; the byte interface is open only
  // while an image is being parsed.
  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state_reg)
      ST_IDLE: ;
      ST_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ST_ERROR: error = 1'b1;
      ST_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (n_full > MAX_N)      state_next = ST_ERROR;
          else if (n_full == '0)   state_next = ST_CHECK;
          else                     state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (word_end && (word_cnt_reg + 1'b1 == len_reg)) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_next = (rx_data == acc_reg) ? ST_DONE : ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
    if (launch) state_next = ST_LEN_HI;
  end

  // State register plus checksum, length, word counting and address tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      len_hi_reg   <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      loaded_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        acc_reg      <= '0;
        len_reg      <= '0;
        word_cnt_reg <= '0;
        addr_reg     <= '0;
        loaded_reg   <= '0;
      end else begin
        // The checksum byte itself is never folded into the accumulator.
        if (rx_valid && (state_reg inside {ST_LEN_HI, ST_LEN_LO, ST_DATA}))
          acc_reg <= acc_reg ^ rx_data;
        if (rx_valid && state_reg == ST_LEN_HI)
          len_hi_reg <= rx_data;
        // Oversized lengths divert to ERROR, so truncation here is harmless.
        if (rx_valid && state_reg == ST_LEN_LO)
          len_reg <= n_full[ADDR_WIDTH:0];
        if (word_end)
          word_cnt_reg <= word_cnt_reg + 1'b1;
        // Address and count advance in the cycle after the write strobe.
        if (word_valid) begin
          addr_reg   <= addr_reg + 1'b1;
          loaded_reg <= loaded_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued
// as each image is issued and a negedge monitor checks every imem_we.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  int n_vec = 0;
  int n_bad = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  img_q[$];
  logic [39:0] mon_exp;

  imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Flags packed as {busy, done, error, cpu_reset, rx_ready}.
  task automatic chk_status(input string tag, input logic [4:0] flags, input logic [AW:0] wl);
    chk({tag, "_flags"}, {35'd0, busy, done, error, cpu_reset, rx_ready}, {35'd0, flags});
    chk({tag, "_words_loaded"}, {31'd0, words_loaded}, {31'd0, wl});
  endtask

  // Monitor: every write strobe must match the next queued {addr, data}.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("imem_write", {imem_addr, imem_wdata}, mon_exp);
      end
    end
  end

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] w, input bit expect_write);
    img_q.push_back(w[31:24]);
    img_q.push_back(w[23:16]);
    img_q.push_back(w[15:8]);
    img_q.push_back(w[7:0]);
    if (expect_write) exp_q.push_back({a, w});
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic pulse);
    bit took;
    took = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      start    = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = pulse;
    for (int k = 0; k < 50 && !took; k++) begin
      took = rx_ready;
      @(posedge clk);
      if (!took) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    if (!took) begin
      n_vec++;
      n_bad++;
      $display("FAIL byte_timeout: got rx_ready 0 for 50 cycles, required 1");
    end
  endtask

  // Sends img_q, returning on the negedge after the last byte was taken.
  task automatic send_image(input int max_gap, input int start_idx);
    for (int i = 0; i < img_q.size(); i++)
      send_byte(img_q[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, i == start_idx);
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    img_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_n3(input logic [7:0] cks);
    img_q.push_back(8'h00);
    img_q.push_back(8'h03);
    push_word(0, 32'h20010005, 1'b1);
    push_word(1, 32'h20020003, 1'b1);
    push_word(2, 32'h00221822, 1'b1);
    img_q.push_back(cks);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_status("reset", 5'b00010, 0);
    chk("reset_addr_data", {imem_we, 7'd0, imem_addr, imem_wdata}, 48'd0);
    reset = 1'b0;

    // Bytes offered in IDLE must be ignored.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk_status("idle_rx", 5'b00010, 0);

    // N=3, correct checksum 0x1E.
    build_n3(8'h1E);
    pulse_start();
    chk_status("n3_busy", 5'b10011, 0);
    send_image(0, -1);
    chk_status("n3_done", 5'b01000, 3);

    // Same image, checksum corrupted.
    build_n3(8'h1F);
    pulse_start();
    send_image(0, -1);
    chk_status("n3_badck", 5'b00110, 3);

    // Empty image: N=0, checksum 0x00.
    img_q = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_image(0, -1);
    chk_status("n0", 5'b01000, 0);

    // Oversized length 0x0101: ERROR one cycle after LEN_LO acceptance.
    img_q = '{8'h01, 8'h01};
    pulse_start();
    send_image(0, -1);
    chk_status("oversize", 5'b00110, 0);

    // N=2 with random gaps and a start pulse during the load; checksum 0x28.
    img_q.push_back(8'h00);
    img_q.push_back(8'h02);
    push_word(0, 32'hDEADBEEF, 1'b1);
    push_word(1, 32'h12345678, 1'b1);
    img_q.push_back(8'h28);
    pulse_start();
    send_image(5, 3);
    chk_status("n2_gaps", 5'b01000, 2);

    // N=4 interrupted by reset after 6 data bytes: only word 0 is written.
    img_q = '{8'h00, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22};
    exp_q.push_back({8'd0, 32'h11111111});
    pulse_start();
    send_image(0, -1);
    chk_status("pre_reset", 5'b10011, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_status("mid_reset", 5'b00010, 0);
    chk("mid_reset_addr_data", {imem_we, 7'd0, imem_addr, imem_wdata}, 48'd0);
    reset = 1'b0;

    // Fresh full N=4 image, checksum 0x04.
    img_q.push_back(8'h00);
    img_q.push_back(8'h04);
    push_word(0, 32'h11111111, 1'b1);
    push_word(1, 32'h22222222, 1'b1);
    push_word(2, 32'h33333333, 1'b1);
    push_word(3, 32'h44444444, 1'b1);
    img_q.push_back(8'h04);
    pulse_start();
    send_image(0, -1);
    chk_status("n4_done", 5'b01000, 4);

    repeat (3) @(negedge clk);
    chk("pending_writes", 40'(exp_q.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
